// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory responder.
package imem_pkg;

    // Load sequencer states: held in RESET while reset is asserted, LOAD
    // while the program image streams in, DONE once the image is complete.
    typedef enum logic [1:0] {
        RESET = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2
    } ld_state_t;

    // Value returned for fetches that are errored or arrive before the
    // image has been loaded.
    localparam logic [31:0] FILL_WORD_DEFAULT = 32'h0000_0000;

    // Width of a word index into a memory of the given depth. A depth of
    // one still needs a one-bit index so that slices stay legal.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : imem_pkg

// File: rtl/imem_rd_pipe.sv
// Extra read-latency stages placed after the stage-0 read register.
// Carries the packed {err, data} result; LATENCY=1 means no extra stages.
module imem_rd_pipe #(
    parameter int             W         = 33,
    parameter int             LATENCY   = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    generate
        if (LATENCY <= 1) begin : g_pass
            // Single-cycle latency: stage 0 already drives the bus.
            logic unused_pipe_inputs;
            assign unused_pipe_inputs = clk_i ^ reset_ni;
            assign out_o = in_i;
        end else begin : g_stages
            logic [W-1:0] stage_q [LATENCY-1];

            // Shift the result one stage per edge; all stages reset to the idle value.
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= in_i;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign out_o = stage_q[LATENCY-2];
        end
    endgenerate

endmodule : imem_rd_pipe

// File: rtl/imem_responder.sv
// Word-addressed instruction memory. A streaming load port fills the
// array once after reset; afterwards every cycle the fetch address is
// looked up and the word (or FILL_WORD with an error flag) is presented
// on the bus after LATENCY registered stages.
//
// Load handshake: a beat transfers on a rising edge where ld_valid_i and
// ld_ready_o are both 1. ld_ready_o depends only on internal state, never
// on ld_valid_i; the source may hold ld_valid_i/ld_data_i/ld_last_i stable
// until the transfer, and must not expect any beat to be taken once
// ld_done_o is 1.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                   BUS_WIDTH   = 32,
    parameter int                   AD_LEN      = 32,
    parameter int                   DEPTH_WORDS = 1024,
    parameter int                   LATENCY     = 1,
    parameter logic [BUS_WIDTH-1:0] FILL_WORD   = BUS_WIDTH'(FILL_WORD_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [AD_LEN-1:0]    bus_ad_i,
    output logic [BUS_WIDTH-1:0] bus_data_o,
    output logic                 bus_err_o,
    input  logic                 ld_valid_i,
    input  logic [BUS_WIDTH-1:0] ld_data_i,
    input  logic                 ld_last_i,
    output logic                 ld_ready_o,
    output logic                 ld_done_o,
    output ld_state_t            dbg_state_o
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);

    // One past the highest legal byte address, one bit wider than the bus
    // so the comparison can never wrap.
    localparam logic [AD_LEN:0] ADDR_LIMIT = (AD_LEN+1)'(DEPTH_WORDS) << 2;

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DEPTH_WORDS - 1);

    localparam logic [BUS_WIDTH:0] RD_IDLE = {1'b0, FILL_WORD};

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    ld_state_t        state;
    logic [IDX_W-1:0] ld_ptr;
    logic             ld_ready_q;
    logic             ld_done_q;
    logic             ld_fire;
    logic             ptr_at_top;

    // ld_ready_q is only ever 1 in LOAD, so a fire implies LOAD.
    assign ld_fire    = ld_valid_i && ld_ready_q;
    assign ptr_at_top = (ld_ptr == TOP_IDX);

    // Sequence the image load; ready and done are registered and swap on the finishing edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= RESET;
            ld_ptr     <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            case (state)
                RESET: begin
                    state      <= LOAD;
                    ld_ready_q <= 1'b1;
                end
                LOAD: begin
                    if (ld_fire) begin
                        ld_ptr <= ld_ptr + IDX_W'(1);
                        // Stop on the declared last beat or when the array is full,
                        // so nothing is ever written past the top word.
                        if (ld_last_i || ptr_at_top) begin
                            state      <= DONE;
                            ld_ready_q <= 1'b0;
                            ld_done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state      <= RESET;
                    ld_ready_q <= 1'b0;
                    ld_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready_o  = ld_ready_q;
    assign ld_done_o   = ld_done_q;
    assign dbg_state_o = state;

    // ------------------------------------------------------------------
    // Storage: contents survive reset, only the load port writes.
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] mem [DEPTH_WORDS];

    // Single write port driven by accepted load beats.
    always_ff @(posedge clk_i) begin
        if (ld_fire) begin
            mem[ld_ptr] <= ld_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Fetch lookup, evaluated against the state before the edge.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] rd_idx;
    logic             rd_aligned;
    logic             rd_in_range;
    logic             rd_good;

    assign rd_idx      = bus_ad_i[IDX_W+1:2];
    assign rd_aligned  = (bus_ad_i[1:0] == 2'b00);
    assign rd_in_range = ({1'b0, bus_ad_i} < ADDR_LIMIT);
    assign rd_good     = rd_aligned && rd_in_range && (state == DONE);

    logic [BUS_WIDTH:0] rd_s0_q;   // {err, data}

    // Stage 0: capture either the addressed word or the error fill value.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_s0_q <= RD_IDLE;
        end else if (rd_good) begin
            rd_s0_q <= {1'b0, mem[rd_idx]};
        end else begin
            rd_s0_q <= {1'b1, FILL_WORD};
        end
    end

    logic [BUS_WIDTH:0] rd_out;

    imem_rd_pipe #(
        .W         (BUS_WIDTH + 1),
        .LATENCY   (LATENCY),
        .RESET_VAL (RD_IDLE)
    ) u_rd_pipe (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .in_i     (rd_s0_q),
        .out_o    (rd_out)
    );

    assign bus_err_o  = rd_out[BUS_WIDTH];
    assign bus_data_o = rd_out[BUS_WIDTH-1:0];

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (latency 1 and 3) share one
// stimulus stream; a reference model predicts every cycle's bus result
// and a monitor compares each instance against its expected queue.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int          BW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 1024;
  localparam int          LAT3  = 3;
  localparam logic [31:0] FILL  = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] bus_ad = '0;
  logic          ld_valid = 1'b0;
  logic [BW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;

  logic [BW-1:0] data1, data3;
  logic          err1, err3, ready1, ready3, done1, done3;
  ld_state_t     state1, state3;

  imem_responder #(.BUS_WIDTH(BW), .AD_LEN(AW), .DEPTH_WORDS(DEPTH), .LATENCY(1), .FILL_WORD(FILL)) u_dut1 (
    .clk_i(clk), .reset_ni(reset_n), .bus_ad_i(bus_ad), .bus_data_o(data1), .bus_err_o(err1),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready1), .ld_done_o(done1), .dbg_state_o(state1)
  );

  imem_responder #(.BUS_WIDTH(BW), .AD_LEN(AW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT3), .FILL_WORD(FILL)) u_dut3 (
    .clk_i(clk), .reset_ni(reset_n), .bus_ad_i(bus_ad), .bus_data_o(data3), .bus_err_o(err3),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready3), .ld_done_o(done3), .dbg_state_o(state3)
  );

  // ---------------- reference model ----------------
  logic [BW-1:0] m_mem [DEPTH];
  int            m_ptr;
  bit            m_ready;
  bit            m_done;
  logic [BW:0]   dly3[$];       // results in flight towards the latency-3 bus

  // ---------------- scoreboard ----------------
  logic [BW+2:0] exp_q1[$];     // {ready, done, err, data}
  logic [BW:0]   exp_q3[$];     // {err, data}
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [BW:0] model_read(input logic [AW-1:0] a);
    if (a[1:0] == 2'b00 && a < 32'(DEPTH * 4) && m_done)
      return {1'b0, m_mem[a >> 2]};
    return {1'b1, FILL};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus: predict the bus result from the state before
  // the edge, then advance the load model and queue the expectations.
  task automatic step();
    logic [BW:0] r;
    r = model_read(bus_ad);
    if (m_ready && ld_valid) begin
      m_mem[m_ptr] = ld_data;
      m_ptr++;
      if (ld_last || m_ptr == DEPTH) begin
        m_ready = 1'b0;
        m_done  = 1'b1;
      end
    end else if (!m_ready && !m_done) begin
      m_ready = 1'b1;
    end
    dly3.push_back(r);
    @(posedge clk);
    exp_q1.push_back({m_ready, m_done, r});
    exp_q3.push_back(dly3.pop_front());
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    reset_n  = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    check("rst_data1", 64'(data1), 64'(FILL));
    check("rst_err1", 64'(err1), 64'(0));
    check("rst_ready1", 64'(ready1), 64'(0));
    check("rst_done1", 64'(done1), 64'(0));
    check("rst_state1", 64'(state1), 64'(RESET));
    check("rst_data3", 64'(data3), 64'(FILL));
    check("rst_err3", 64'(err3), 64'(0));
    exp_q1.delete();
    exp_q3.delete();
    dly3.delete();
    for (int i = 0; i < LAT3 - 1; i++) dly3.push_back({1'b0, FILL});
    m_ptr   = 0;
    m_ready = 1'b0;
    m_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic load_beat(input logic [BW-1:0] d, input logic last, input logic [AW-1:0] a);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    bus_ad   = a;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] a);
    bus_ad = a;
    step();
  endtask

  // ---------------- monitor ----------------
  logic [BW+2:0] e1;
  logic [BW:0]   e3;
  always @(negedge clk) begin
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      n_cmp++;
      if ({ready1, done1, err1, data1} !== e1) begin
        n_bad++;
        $display("FAIL lat1_bus: got rdy=%b done=%b err=%b data=%h, expected rdy=%b done=%b err=%b data=%h (t=%0t)",
                 ready1, done1, err1, data1, e1[BW+2], e1[BW+1], e1[BW], e1[BW-1:0], $time);
      end
    end
    if (exp_q3.size() > 0) begin
      e3 = exp_q3.pop_front();
      n_cmp++;
      if ({err3, data3} !== e3) begin
        n_bad++;
        $display("FAIL lat3_bus: got err=%b data=%h, expected err=%b data=%h (t=%0t)",
                 err3, data3, e3[BW], e3[BW-1:0], $time);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [BW-1:0] w4 [4];
  logic [AW-1:0] a;

  initial begin
    w4[0] = 32'h1111_1111; w4[1] = 32'h2222_2222;
    w4[2] = 32'h3333_3333; w4[3] = 32'h4444_4444;

    // Reset, then fetch 0x0 with nothing loaded.
    apply_reset();
    repeat (4) read(32'h0);

    // Four-beat image, last on beat 4.
    for (int i = 0; i < 4; i++) load_beat(w4[i], (i == 3), 32'h8);
    check("done_state", 64'(state1), 64'(DONE));
    read(32'h8);
    for (int i = 0; i < 4; i++) read(32'(i * 4));
    read(32'h6);
    read(32'h1000);
    read(32'h4);
    repeat (3) read(32'hC);
    read(32'hFFFF_FFFC);
    for (int i = 0; i < 40; i++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = $urandom;
      ld_last  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: a = 32'($urandom_range(0, 15));
        1: a = 32'($urandom_range(32'h1000, 32'h1010));
        default: a = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      endcase
      read(a);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;

    // Full-depth image with no last marker, then a beat that must be ignored.
    apply_reset();
    read(32'h0);
    for (int i = 0; i < DEPTH; i++) load_beat($urandom, 1'b0, 32'($urandom_range(0, 32'h1003)));
    check("full_done_state", 64'(state1), 64'(DONE));
    load_beat(32'hBAD0_BAD0, 1'b1, 32'hFFC);
    read(32'hFFC);
    read(32'h0);
    read(32'hFFE);
    read(32'h1000);
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 32'h1003));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      read(a);
    end

    // Reset in the middle of a load, then reload fresh data from index 0.
    apply_reset();
    read(32'h0);
    for (int i = 0; i < 2; i++) load_beat($urandom, 1'b0, 32'h4);
    apply_reset();
    read(32'h4);
    for (int i = 0; i < 4; i++) load_beat(32'hA5A5_0000 | 32'(i), (i == 3), 32'h0);
    for (int i = 0; i < 4; i++) read(32'(i * 4));
    for (int i = 0; i < 30; i++) read(32'($urandom_range(0, 32'h1FFF)));

    // Drain the scoreboard.
    bus_ad = '0;
    @(negedge clk);
    #1;
    check("drain_q1", 64'(exp_q1.size()), 64'(0));
    check("drain_q3", 64'(exp_q3.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imem_responder

// File: doc/imem_responder.md
# imem_responder

Word-addressed instruction memory that answers the CPU fetch unit's bus requests: it samples the fetch address, returns the addressed word on the bus data lines after a fixed registered latency, and flags misaligned or out-of-range accesses. Before answering fetches it is filled through a streaming load port, for example from a boot loader or test bench. It sits between the CPU core's fetch bus and the program image source.

## Interface
- BUS_WIDTH, 32, data word width
- AD_LEN, 32, bus address width
- DEPTH_WORDS, 1024, memory depth in words; power of two, at least 2
- LATENCY, 1, read latency in cycles, range 1..4; the CPU fetch unit requires 1
- FILL_WORD, 32'h0000_0000, value returned for errored or pre-load reads
- clk_i  in  1  clock; all state updates on its rising edge
- reset_ni  in  1  reset; asynchronous, active-low
- bus_ad_i  in  AD_LEN  fetch byte address
- bus_data_o  out  BUS_WIDTH  read data
- bus_err_o  out  1  read error, aligned with bus_data_o
- ld_valid_i  in  1  load beat valid
- ld_data_i  in  BUS_WIDTH  load beat data
- ld_last_i  in  1  final beat of image
- ld_ready_o  out  1  load port can accept a beat
- ld_done_o  out  1  image loaded; fetch reads enabled

## Operation
- Load FSM states: RESET, LOAD, DONE.
- RESET is the state only while reset_ni=0, and LOAD is the state on the first edge after release.
- LOAD: ld_ready_o=1. A beat is accepted when ld_valid_i and ld_ready_o are both 1.
  - An accepted beat writes ld_data_i to mem[ld_ptr], then ld_ptr increments.
  - The FSM goes to DONE when an accepted beat has ld_last_i=1, or when the beat is accepted at ld_ptr=DEPTH_WORDS-1.
  - The FSM never writes beyond the top of memory.
- DONE is sticky until reset: ld_ready_o=0, ld_done_o=1, and valid beats are ignored.
- Read index is bus_ad_i[$clog2(DEPTH_WORDS)+1:2].
- A read is good when all three hold: bus_ad_i[1:0]=0, bus_ad_i < DEPTH_WORDS*4 (compared at full AD_LEN width, with no wrap), and the state is DONE.
- A good read returns mem[index] with err=0.
- A misaligned or out-of-range read returns FILL_WORD with err=1.
- A read before DONE returns FILL_WORD with err=1.
- Memory contents are not reset. A reset during load discards progress (ld_ptr=0), and the image must be reloaded.

## Timing
- Reset values: bus_data_o=FILL_WORD, bus_err_o=0, ld_ready_o=0, ld_done_o=0, ld_ptr=0.
- Read path: stage 0 registers the data/err result on edge k from bus_ad_i as it stood before edge k. LATENCY-1 further register stages follow.
- bus_data_o/bus_err_o change only on edge k+LATENCY-1.
- With LATENCY=1:
  - The fetch unit drives the address after its request edge N.
  - The responder registers the data at N+1.
  - The fetch unit samples the data at N+2.
- The read is evaluated combinationally against the state before the edge. The edge that enters DONE therefore still produces an err=1 result, and the first good read is registered on the next edge.
- Loading is one beat per cycle at full throughput.
- ld_ready_o and ld_done_o are registered. ld_ready_o drops on the same edge that sets ld_done_o.
- An address held constant yields a constant output; there is no request strobe.

## Structure
- Package imem_pkg holds:
  - the ld_state_t enum (RESET, LOAD, DONE)
  - the localparam helper for index width
  - the FILL_WORD default
- One sub-module, imem_rd_pipe: a parameterised LATENCY-1 stage register chain carrying {err, data}.
  - It resets to {0, FILL_WORD}.
  - With LATENCY=1 it passes through.
- Memory is an inferred synchronous-write array: a single write port from the load FSM, and a read port feeding the stage-0 register.

## Test plan
- Reset, then immediate fetch of 0x0 with no load: bus_data_o=FILL_WORD, err=1 each cycle; ld_ready_o=1 one edge after release.
- Load 4 beats (0x11111111, 0x22222222, 0x33333333, 0x44444444, last on beat 4): ld_done_o=1 after beat 4; address 0x8 reads 0x33333333 err=0 one edge after drive. Pair with the fetch unit: the fetch unit emits the four words in order, with pc stepping 0, 4, 8, C.
- Misaligned 0x6 and out-of-range DEPTH_WORDS*4 (0x1000): FILL_WORD, err=1; then 0x4 reads 0x22222222 err=0.
- Load DEPTH_WORDS beats with ld_last_i never asserted: DONE after beat DEPTH_WORDS; an extra valid beat is ignored; the top word reads back intact.
- Reset asserted mid-load (after beat 2 of 4): outputs immediately take their reset values; a reload from 0 with new data reads back the new data.
- LATENCY=3 build: an address change is reflected exactly 2 edges after the first sampling edge; intermediate cycles hold the old value.
